// File: rtl/ieee754_settle_capture.sv
// ieee754_settle_capture
//   Samples an IEEE-754 single on each rising edge of a slow strobe and declares it settled
//   after SETTLE_COUNT consecutive equal samples. The settled value is then converted to
//   signed Q16.16 by a bit-serial shifter, and the result is presented with a one-cycle pulse.
//
//   Optional feature: define IEEE754_ROUND_EN to round right shifts half away from zero
//   (magnitude += last bit shifted out). Without it, right shifts truncate toward zero.
//
// Ports
//   clk        : single clock, rising edge
//   reset_n    : synchronous active-low reset
//   clk_100k   : sample strobe, treated as data (rising edge detected here)
//   float_in   : IEEE-754 single-precision input
//   stable_cnt : current equal-run count, saturates at SETTLE_COUNT
//   settled    : equal run has reached SETTLE_COUNT
//   fix_out    : signed Q16.16 result, held between pulses
//   fix_valid  : one-cycle pulse when fix_out updates
//   ovf        : last conversion saturated
//   nan        : last converted input was NaN
module ieee754_settle_capture #(
  parameter int unsigned SETTLE_COUNT = 20,
  parameter int unsigned CNT_W        = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clk_100k,
  input  logic [31:0]      float_in,
  output logic [CNT_W-1:0] stable_cnt,
  output logic             settled,
  output logic [31:0]      fix_out,
  output logic             fix_valid,
  output logic             ovf,
  output logic             nan
);

  localparam logic [CNT_W-1:0] SettleCnt = CNT_W'(SETTLE_COUNT);

  typedef enum logic [1:0] {StIdle, StLoad, StShift, StFix} state_e;

  state_e           state_q;
  logic             clk_100k_q;
  logic [31:0]      last_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             settled_q, settled_d;
  logic             sign_q, sat_q, nanf_q, left_q;
  logic [31:0]      mag_q;
  logic [4:0]       sh_cnt_q;
`ifdef IEEE754_ROUND_EN
  logic             guard_q;
`endif

  logic tick, mismatch, abort, launch;

  assign tick     = clk_100k & ~clk_100k_q;
  assign mismatch = (float_in != last_q);
  assign abort    = tick & mismatch;

  // Stability counter next state
  always_comb begin
    cnt_d     = cnt_q;
    settled_d = settled_q;
    if (tick) begin
      if (mismatch) begin
        cnt_d     = '0;
        settled_d = 1'b0;
      end else begin
        if (cnt_q != SettleCnt) cnt_d = cnt_q + 1'b1;
        settled_d = settled_q | (cnt_d == SettleCnt);
      end
    end
  end

  // Only the rising edge of settled starts a conversion
  assign launch = settled_d & ~settled_q;

  // Classification of the settled value (read in StLoad from last_q)
  logic [7:0]  exp_w;
  logic [22:0] man_w;
  logic        cls_nan, cls_sat, cls_zero, cls_left;
  logic [4:0]  cls_n;

  always_comb begin
    exp_w    = last_q[30:23];
    man_w    = last_q[22:0];
    cls_nan  = (exp_w == 8'd255) && (man_w != '0);
    cls_sat  = !cls_nan && (exp_w >= 8'd142);
    cls_zero = (exp_w < 8'd110);
    cls_left = (exp_w > 8'd134);
    // Q16.16 weight of the mantissa LSB is 2^(e-134)
    cls_n    = cls_left ? 5'(exp_w - 8'd134) : 5'(8'd134 - exp_w);
  end

  // Final rounding, saturation and negation
  logic [32:0] rmag;
  logic        fix_sat;
  logic [31:0] fix_res;

  always_comb begin
`ifdef IEEE754_ROUND_EN
    rmag = {1'b0, mag_q} + {32'b0, guard_q};
`else
    rmag = {1'b0, mag_q};
`endif
    fix_sat = sat_q | (rmag > 33'h0_7FFF_FFFF);
    if (nanf_q)       fix_res = '0;
    else if (fix_sat) fix_res = sign_q ? 32'h8000_0000 : 32'h7FFF_FFFF;
    else if (sign_q)  fix_res = 32'd0 - rmag[31:0];
    else              fix_res = rmag[31:0];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      clk_100k_q <= 1'b0;
      last_q     <= '0;
      cnt_q      <= '0;
      settled_q  <= 1'b0;
      sign_q     <= 1'b0;
      sat_q      <= 1'b0;
      nanf_q     <= 1'b0;
      left_q     <= 1'b0;
      mag_q      <= '0;
      sh_cnt_q   <= '0;
`ifdef IEEE754_ROUND_EN
      guard_q    <= 1'b0;
`endif
      fix_out    <= '0;
      fix_valid  <= 1'b0;
      ovf        <= 1'b0;
      nan        <= 1'b0;
    end else begin
      clk_100k_q <= clk_100k;
      if (tick) last_q <= float_in;
      cnt_q     <= cnt_d;
      settled_q <= settled_d;
      fix_valid <= 1'b0;

      if (abort) begin
        state_q <= StIdle;
      end else begin
        unique case (state_q)
          StIdle: if (launch) state_q <= StLoad;
          StLoad: begin
            sign_q   <= last_q[31];
            nanf_q   <= cls_nan;
            sat_q    <= cls_sat;
            left_q   <= cls_left;
            sh_cnt_q <= cls_n;
`ifdef IEEE754_ROUND_EN
            guard_q  <= 1'b0;
`endif
            if (cls_nan || cls_sat || cls_zero) begin
              mag_q   <= '0;
              state_q <= StFix;
            end else begin
              mag_q   <= {8'b0, 1'b1, man_w};
              state_q <= (cls_n == '0) ? StFix : StShift;
            end
          end
          StShift: begin
            if (left_q) begin
              mag_q <= {mag_q[30:0], 1'b0};
            end else begin
              mag_q <= {1'b0, mag_q[31:1]};
`ifdef IEEE754_ROUND_EN
              guard_q <= mag_q[0];
`endif
            end
            sh_cnt_q <= sh_cnt_q - 1'b1;
            if (sh_cnt_q == 5'd1) state_q <= StFix;
          end
          StFix: begin
            fix_out   <= fix_res;
            ovf       <= ~nanf_q & fix_sat;
            nan       <= nanf_q;
            fix_valid <= 1'b1;
            state_q   <= StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign stable_cnt = cnt_q;
  assign settled    = settled_q;

endmodule

// File: tb/tb_ieee754_settle_capture.sv
module tb_ieee754_settle_capture;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        clk_100k = 1'b0;
  logic [31:0] float_in = '0;
  logic [9:0]  stable_cnt;
  logic        settled;
  logic [31:0] fix_out;
  logic        fix_valid;
  logic        ovf;
  logic        nan;

  ieee754_settle_capture dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .clk_100k   (clk_100k),
    .float_in   (float_in),
    .stable_cnt (stable_cnt),
    .settled    (settled),
    .fix_out    (fix_out),
    .fix_valid  (fix_valid),
    .ovf        (ovf),
    .nan        (nan)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] out;
    logic        ovf;
    logic        nan;
    logic [7:0]  lat;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  // Pulse monitor: captures each result and its latency from the settled rise
  int          cyc = 0, rise_cyc = 0, pulse_cnt = 0, lat = 0;
  logic        settled_prev = 1'b0;
  logic [31:0] cap_out = '0;
  logic        cap_ovf = 1'b0, cap_nan = 1'b0;

  always @(negedge clk) begin
    cyc          <= cyc + 1;
    settled_prev <= settled;
    if (settled === 1'b1 && settled_prev !== 1'b1) rise_cyc <= cyc;
    if (fix_valid === 1'b1) begin
      pulse_cnt <= pulse_cnt + 1;
      cap_out   <= fix_out;
      cap_ovf   <= ovf;
      cap_nan   <= nan;
      lat       <= cyc - rise_cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      failures++;
      $error("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  task automatic tick_once(input logic [31:0] v);
    @(negedge clk);
    float_in = v;
    clk_100k = 1'b1;
    repeat (20) @(negedge clk);
    clk_100k = 1'b0;
    repeat (19) @(negedge clk);
  endtask

  task automatic do_ticks(input logic [31:0] v, input int n);
    for (int i = 0; i < n; i++) tick_once(v);
  endtask

  // Full settle + convert run; expects the value to differ from the previous one
  task automatic run_conv(input string tag, input logic [31:0] v, input logic [31:0] eo,
                          input logic eovf, input logic enan, input logic [7:0] elat);
    int   p0;
    exp_t e;
    p0 = pulse_cnt;
    exp_q.push_back('{out: eo, ovf: eovf, nan: enan, lat: elat});
    do_ticks(v, 20);
    chk({tag, "_cnt19"}, 32'(stable_cnt), 32'd19);
    chk({tag, "_not_settled"}, 32'(settled), 32'd0);
    do_ticks(v, 1);
    chk({tag, "_settled"}, 32'(settled), 32'd1);
    chk({tag, "_cnt20"}, 32'(stable_cnt), 32'd20);
    chk({tag, "_one_pulse"}, 32'(pulse_cnt - p0), 32'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk({tag, "_out"}, cap_out, e.out);
      chk({tag, "_ovf"}, 32'(cap_ovf), 32'(e.ovf));
      chk({tag, "_nan"}, 32'(cap_nan), 32'(e.nan));
      chk({tag, "_lat"}, 32'(lat), 32'(e.lat));
    end
    do_ticks(v, 1);
    chk({tag, "_cnt_sat"}, 32'(stable_cnt), 32'd20);
    chk({tag, "_no_reconv"}, 32'(pulse_cnt - p0), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int          p0;
    logic [31:0] tiny_exp;
`ifdef IEEE754_ROUND_EN
    tiny_exp = 32'h0000_0001;
`else
    tiny_exp = 32'h0000_0000;
`endif

    repeat (3) @(negedge clk);
    chk("rst_cnt", 32'(stable_cnt), 32'd0);
    chk("rst_settled", 32'(settled), 32'd0);
    chk("rst_fix_out", fix_out, 32'd0);
    chk("rst_valid", 32'(fix_valid), 32'd0);
    chk("rst_ovf_nan", {30'd0, ovf, nan}, 32'd0);
    reset_n = 1'b1;

    run_conv("one",     32'h3F80_0000, 32'h0001_0000, 1'b0, 1'b0, 8'd9);
    run_conv("m2p5",    32'hC020_0000, 32'hFFFD_8000, 1'b0, 1'b0, 8'd8);
    run_conv("big",     32'h4700_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 8'd2);
    run_conv("ninf",    32'hFF80_0000, 32'h8000_0000, 1'b1, 1'b0, 8'd2);
    run_conv("qnan",    32'h7FC0_0000, 32'h0000_0000, 1'b0, 1'b1, 8'd2);
    run_conv("p2m17",   32'h3700_0000, tiny_exp,      1'b0, 1'b0, 8'd26);
    run_conv("p2m16",   32'h3780_0000, 32'h0000_0001, 1'b0, 1'b0, 8'd25);

    // Alternating values never accumulate
    p0 = pulse_cnt;
    for (int i = 0; i < 8; i++) begin
      tick_once((i % 2 == 0) ? 32'h3F80_0000 : 32'h4000_0000);
      chk("alt_cnt", 32'(stable_cnt), 32'd0);
    end
    chk("alt_settled", 32'(settled), 32'd0);
    chk("alt_no_pulse", 32'(pulse_cnt - p0), 32'd0);

    // Abort: mismatching tick 3 clk after settled rises
    p0 = pulse_cnt;
    do_ticks(32'h3F80_0000, 20);
    @(negedge clk);
    float_in = 32'h3F80_0000;
    clk_100k = 1'b1;
    @(negedge clk);
    chk("abort_settled_rise", 32'(settled), 32'd1);
    clk_100k = 1'b0;
    repeat (2) @(negedge clk);
    float_in = 32'h4000_0000;
    clk_100k = 1'b1;
    @(negedge clk);
    chk("abort_settled", 32'(settled), 32'd0);
    chk("abort_cnt", 32'(stable_cnt), 32'd0);
    clk_100k = 1'b0;
    repeat (30) @(negedge clk);
    chk("abort_no_pulse", 32'(pulse_cnt - p0), 32'd0);
    chk("abort_fix_held", fix_out, 32'h0000_0001);

    // Reset during SHIFT
    p0 = pulse_cnt;
    do_ticks(32'hC020_0000, 20);
    @(negedge clk);
    clk_100k = 1'b1;
    @(negedge clk);
    clk_100k = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    chk("mrst_cnt", 32'(stable_cnt), 32'd0);
    chk("mrst_settled", 32'(settled), 32'd0);
    chk("mrst_fix_out", fix_out, 32'd0);
    chk("mrst_flags", {29'd0, fix_valid, ovf, nan}, 32'd0);
    reset_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("mrst_no_pulse", 32'(pulse_cnt - p0), 32'd0);
    run_conv("after_rst", 32'hC020_0000, 32'hFFFD_8000, 1'b0, 1'b0, 8'd8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ieee754_settle_capture.md
# ieee754_settle_capture

Downstream consumer of the op-amp model's 32-bit IEEE-754 single-precision output. It watches the output once per sample strobe and declares it settled after a fixed run of identical samples. It then converts the settled value to signed Q16.16 fixed point with a bit-serial shifter and presents the result with a one-cycle valid pulse. This is the synthesizable form of the stability check the op-amp bench performs, feeding fixed-point logic downstream.

## Interface
- `SETTLE_COUNT`, default 20: consecutive equal comparisons required to declare settled (1..2^CNT_W-1).
- `CNT_W`, default 10: width of the stability counter.
- `clk`  in  1: the only clock; all logic on rising edge.
- `reset_n`  in  1: reset is synchronous and active-low.
- `clk_100k`  in  1: sample strobe from the op-amp stage; treated as data, rising edge detected in `clk` domain.
- `float_in`  in  32: IEEE-754 single from the op-amp (`square_out`).
- `stable_cnt`  out  CNT_W: current equal-run count, saturating at SETTLE_COUNT.
- `settled`  out  1: run has reached SETTLE_COUNT.
- `fix_out`  out  32: signed Q16.16 result, held until next `fix_valid`.
- `fix_valid`  out  1: one-cycle pulse when `fix_out` is updated.
- `ovf`  out  1: last conversion saturated; valid with `fix_valid`.
- `nan`  out  1: last input was NaN; valid with `fix_valid`.

## Operation
- Tick: `clk_100k` registered once; tick = `clk_100k & ~clk_100k_q`. A level held across many clk gives one tick.
- On tick: if `float_in == last_q` then `stable_cnt` increments, saturating at SETTLE_COUNT. Otherwise `stable_cnt` goes to 0 and `settled` goes to 0. `last_q <= float_in` on every tick.
- `settled` is set on the edge where `stable_cnt` becomes SETTLE_COUNT. It stays high until a mismatching tick or reset.
- The rising edge of `settled` launches one conversion. No reconversion while settled.
- FSM: IDLE -> LOAD -> SHIFT -> FIX -> IDLE.
- **LOAD:** split sign s, exponent e, mantissa m. Set mag = {1,m} (24 bit) and classify.
  - e==255, m!=0: NaN. Result 0, nan=1.
  - e==255, m==0: Inf. Saturate, ovf=1.
  - e>=142 (|x|>=2^15): saturate, ovf=1.
  - e==0 (zero/denormal): flushed to 0.
  - e<110: result 0.
  - Otherwise shift = e-134. Positive means left by shift (0..7); negative means right by -shift (1..24).
  - Special cases and shift==0 skip SHIFT.
- **SHIFT:** one bit position per clk into a 32-bit magnitude register. On right shifts, the last bit shifted out is kept as the guard bit.
- **FIX:** negate if s=1.
  - Saturation values: +0x7FFFFFFF, -0x80000000.
  - Register `fix_out`, `ovf` and `nan`, and pulse `fix_valid`.
- Abort: a mismatching tick while FSM is not IDLE returns it to IDLE next clk. No `fix_valid` is issued and `fix_out` is unchanged.
- A tick coincident with the FIX cycle that mismatches wins: no pulse.

## Timing
- Reset values: `stable_cnt`=0, `settled`=0, `fix_out`=0, `fix_valid`=0, `ovf`=0, `nan`=0, `last_q`=0, `clk_100k_q`=0, FSM=IDLE. Reset mid-conversion takes effect on the next clk edge with no pulse.
- Tick latency: `stable_cnt` and `settled` update on the clk edge after the clk in which `clk_100k` is first seen high.
- Conversion latency: `fix_valid` is high exactly 2+n clk after `settled` rises, where n = |shift| (0 for special cases). Worst case 26 clk, far below one 100 kHz period.
- `fix_valid` lasts exactly one clk. `fix_out`, `ovf` and `nan` are stable from that cycle until the next pulse.
- The first tick after reset compares against `last_q`=0, so a 0x00000000 input counts from the first tick.

## Configuration
- `IEEE754_ROUND_EN` defined: in FIX, magnitude += guard bit (round half away from zero). If the carry pushes magnitude past 0x7FFFFFFF, the result saturates with ovf=1.
- `IEEE754_ROUND_EN` undefined: right shifts truncate magnitude toward zero and the guard bit is unused.

## Test plan
- Hold 0x3F800000 (1.0), ticks every 10000 clk, default params. Required: `settled` after 20th equal tick; `fix_valid` 9 clk later; `fix_out`=0x00010000, ovf=0, nan=0.
- Hold 0xC0200000 (-2.5). Required: `fix_out`=0xFFFD8000.
- Hold 0x47000000 (32768.0), then 0xFF800000 (-Inf). Required: 0x7FFFFFFF with ovf=1, then 0x80000000 with ovf=1. Hold 0x7FC00000. Required: `fix_out`=0, nan=1.
- Hold 0x37000000 (2^-17). Required: `fix_out`=0 without the macro, 0x00000001 with `IEEE754_ROUND_EN`. Hold 0x37800000. Required: 0x00000001 in both builds.
- Alternate 0x3F800000/0x40000000 on every tick. Required: `stable_cnt` stays 0 and there is no `fix_valid`. Change the value on the tick 3 clk after `settled` rises. Required: abort with no pulse and `settled`=0.
- Assert `reset_n`=0 for one clk during SHIFT. Required: all outputs zero on the following edge, no `fix_valid`, and a fresh 20-tick run is needed before the next conversion.
